// File: rtl/move_input_encoder_if.sv
// move_input_encoder_if: button inputs and the move valid/ack handshake between the encoder and the game FSM
interface move_input_encoder_if;
  logic [6:0] btn;
  logic [2:0] x;
  logic       x_valid;
  logic       x_ack;
  logic       busy;
  logic       err_timeout;
  modport master (input btn, x_ack, output x, x_valid, busy, err_timeout);
  modport slave  (output btn, x_ack, input x, x_valid, busy, err_timeout);
endinterface

// File: rtl/move_input_encoder.sv
// move_input_encoder: synchronizes and debounces 7 buttons, then presents one move per press as a 3-bit code; optional MOVE_TIMEOUT_EN drops unacknowledged moves
module move_input_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input logic clk,
  input logic rst,
  move_input_encoder_if.master bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {IDLE, HOLD, RELEASE} state_t;
  state_t st, st_n;
  logic [6:0] s1, s2, deb;
  logic [6:0][CW-1:0] cnt;
  logic [2:0] code, x_n;
  logic v_n, tmo;
  // two-flop synchronizer, then a level is accepted only after DEBOUNCE_CYCLES stable disagreeing samples
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      deb <= '0;
      cnt <= '0;
    end else begin
      s1 <= bus.btn;
      s2 <= s1;
      for (int i = 0; i < 7; i++)
        if (s2[i] == deb[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + CW'(1);
    end
  // lowest pressed index wins
  always_comb begin
    code = '0;
    for (int i = 6; i >= 0; i--) if (deb[i]) code = 3'(i + 1);
  end
  // state and the registered move outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      bus.x <= '0;
      bus.x_valid <= 1'b0;
    end else begin
      st <= st_n;
      bus.x <= x_n;
      bus.x_valid <= v_n;
    end
  // latch a move from IDLE, hold it until ack or timeout, then wait for all buttons released
  always_comb begin
    st_n = st;
    x_n = bus.x;
    v_n = bus.x_valid;
    case (st)
      IDLE:
        if (|deb) begin
          st_n = HOLD;
          x_n = code;
          v_n = 1'b1;
        end
      HOLD:
        if (bus.x_ack || tmo) begin
          st_n = RELEASE;
          x_n = '0;
          v_n = 1'b0;
        end
      RELEASE: st_n = deb == '0 ? IDLE : RELEASE;
      default: st_n = IDLE;
    endcase
  end
  assign bus.busy = st != IDLE;
`ifdef MOVE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] hcnt;
  assign tmo = hcnt == TW'(TIMEOUT_CYCLES - 1);
  // hold counter runs only in HOLD; an ack on the timeout edge suppresses the error pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hcnt <= '0;
      bus.err_timeout <= 1'b0;
    end else begin
      hcnt <= st == HOLD ? hcnt + TW'(1) : '0;
      bus.err_timeout <= st == HOLD && !bus.x_ack && tmo;
    end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tmo = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_move_input_encoder.sv
// tb_move_input_encoder: scoreboard bench; expected move codes are queued at press time and checked as each move appears
module tb_move_input_encoder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  int q[$];
  int cur = 0;
  logic pv = 1'b0;
  move_input_encoder_if bus();
  move_input_encoder #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic wait_valid();
    int n = 0;
    while (!bus.x_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("wait_valid", 0, 1);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("wait_idle", 1, 0);
  endtask
  task automatic drive(input logic [6:0] b);
    @(posedge clk);
    #2 bus.btn = b;
  endtask
  task automatic ack();
    @(posedge clk);
    #2 bus.x_ack = 1'b1;
    @(posedge clk);
    #2 bus.x_ack = 1'b0;
    @(negedge clk);
    chk("ack_valid", int'(bus.x_valid), 0);
    chk("ack_x", int'(bus.x), 0);
  endtask
  always @(negedge clk) begin
    if (bus.x_valid && !pv) begin
      if (q.size() == 0) chk("extra_move", int'(bus.x), 0);
      else cur = q.pop_front();
    end
    if (bus.x_valid) chk("x_hold", int'(bus.x), cur);
    else chk("x_idle", int'(bus.x), 0);
`ifndef MOVE_TIMEOUT_EN
    chk("err_tied", int'(bus.err_timeout), 0);
`endif
    pv = bus.x_valid;
  end
  initial begin
    bus.btn = '0;
    bus.x_ack = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(bus.x_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_err", int'(bus.err_timeout), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    // single press: latency and ack
    drive(7'b0000010);
    q.push_back(2);
    repeat (7) @(negedge clk);
    chk("lat_pre", int'(bus.x_valid), 0);
    @(negedge clk);
    chk("lat_on", int'(bus.x_valid), 1);
    chk("lat_x", int'(bus.x), 2);
    chk("lat_busy", int'(bus.busy), 1);
    repeat (2) @(posedge clk);
    #2 bus.x_ack = 1'b1;
    @(posedge clk);
    #2 bus.x_ack = 1'b0;
    @(negedge clk);
    chk("ack10_valid", int'(bus.x_valid), 0);
    chk("ack10_busy", int'(bus.busy), 1);
    repeat (10) @(negedge clk);
    chk("hold_release", int'(bus.busy), 1);
    drive(7'b0);
    wait_idle();
    chk("idle_again", int'(bus.busy), 0);
    // bounce rejection on btn[4]
    for (int i = 0; i < 4; i++) begin
      drive(i % 2 == 0 ? 7'b0010000 : 7'b0);
      @(posedge clk);
    end
    repeat (15) @(negedge clk);
    chk("bounce_valid", int'(bus.x_valid), 0);
    chk("bounce_busy", int'(bus.busy), 0);
    // simultaneous presses: lowest index wins
    drive(7'b0100100);
    q.push_back(3);
    wait_valid();
    chk("prio_x", int'(bus.x), 3);
    ack();
    drive(7'b0);
    wait_idle();
    drive(7'b0100000);
    q.push_back(6);
    wait_valid();
    chk("solo_x", int'(bus.x), 6);
    ack();
    drive(7'b0);
    wait_idle();
    // presses while busy are discarded
    drive(7'b0000001);
    q.push_back(1);
    wait_valid();
    drive(7'b1000001);
    repeat (10) @(negedge clk);
    chk("busy_x", int'(bus.x), 1);
    drive(7'b1000000);
    ack();
    repeat (10) @(negedge clk);
    chk("stay_release", int'(bus.busy), 1);
    chk("no_111", int'(bus.x_valid), 0);
    drive(7'b0);
    wait_idle();
    // asynchronous reset while holding a move
    drive(7'b0000010);
    q.push_back(2);
    wait_valid();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_x", int'(bus.x), 0);
    chk("arst_valid", int'(bus.x_valid), 0);
    chk("arst_busy", int'(bus.busy), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    q.push_back(2);
    wait_valid();
    chk("rearm_x", int'(bus.x), 2);
    ack();
    drive(7'b0);
    wait_idle();
`ifdef MOVE_TIMEOUT_EN
    drive(7'b0001000);
    q.push_back(4);
    wait_valid();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("to_held", int'(bus.x_valid), 1);
      chk("to_noerr", int'(bus.err_timeout), 0);
    end
    @(negedge clk);
    chk("to_drop", int'(bus.x_valid), 0);
    chk("to_err", int'(bus.err_timeout), 1);
    @(negedge clk);
    chk("to_pulse", int'(bus.err_timeout), 0);
    drive(7'b0);
    wait_idle();
    drive(7'b0001000);
    q.push_back(4);
    wait_valid();
    repeat (7) @(posedge clk);
    #2 bus.x_ack = 1'b1;
    @(posedge clk);
    #2 bus.x_ack = 1'b0;
    @(negedge clk);
    chk("race_valid", int'(bus.x_valid), 0);
    chk("race_err", int'(bus.err_timeout), 0);
    @(negedge clk);
    chk("race_err2", int'(bus.err_timeout), 0);
    drive(7'b0);
    wait_idle();
`else
    drive(7'b0001000);
    q.push_back(4);
    wait_valid();
    repeat (100) @(negedge clk);
    chk("no_timeout", int'(bus.x_valid), 1);
    chk("no_timeout_x", int'(bus.x), 4);
    ack();
    drive(7'b0);
    wait_idle();
`endif
    chk("q_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
